// File: rtl/slurm16_memory_arbiter.sv
// Two-master (CPU priority, DMA starvation-protected) arbiter onto a single-port
// synchronous RAM with 1-cycle read latency and per-master read-data hold registers.
module slurm16_memory_arbiter #(
    parameter int BITS          = 16,
    parameter int ADDRESS_BITS  = 16,
    parameter int CPU_MAX_BURST = 4
) (
    input  logic                    CLK,
    input  logic                    RSTb,

    input  logic [ADDRESS_BITS-1:0] cpu_address,
    input  logic [BITS-1:0]         cpu_wr_data,
    input  logic                    cpu_valid,
    input  logic                    cpu_wr,
    output logic                    cpu_ready,
    output logic [BITS-1:0]         cpu_rd_data,

    input  logic [ADDRESS_BITS-1:0] dma_address,
    input  logic [BITS-1:0]         dma_wr_data,
    input  logic                    dma_valid,
    input  logic                    dma_wr,
    output logic                    dma_ready,
    output logic [BITS-1:0]         dma_rd_data,

    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [BITS-1:0]         mem_wr_data,
    output logic                    mem_wr_en,
    input  logic [BITS-1:0]         mem_rd_data
);

    localparam int CNT_W = (CPU_MAX_BURST < 1) ? 1 : $clog2(CPU_MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CPU_MAX_BURST);

    logic [CNT_W-1:0] starve_cnt;
    logic             dma_wins;
    logic             grant_cpu;
    logic             grant_dma;
    logic             rd_tag_cpu;
    logic             rd_tag_dma;
    logic [BITS-1:0]  cpu_hold;
    logic [BITS-1:0]  dma_hold;

    // A zero burst limit means the DMA wins every contested cycle.
    generate
        if (CPU_MAX_BURST == 0) begin : g_no_burst
            assign dma_wins = 1'b1;
        end else begin : g_burst
            assign dma_wins = (starve_cnt >= MAX_CNT);
        end
    endgenerate

    always_comb begin
        grant_dma = RSTb && dma_valid && (!cpu_valid || dma_wins);
        grant_cpu = RSTb && cpu_valid && !(dma_valid && dma_wins);
    end

    assign cpu_ready   = grant_cpu;
    assign dma_ready   = grant_dma;
    assign mem_address = grant_dma ? dma_address : cpu_address;
    assign mem_wr_data = grant_dma ? dma_wr_data : cpu_wr_data;
    assign mem_wr_en   = (grant_cpu && cpu_wr) || (grant_dma && dma_wr);

    // Read return stage: the tag marks whose data the RAM presents this cycle.
    assign cpu_rd_data = rd_tag_cpu ? mem_rd_data : cpu_hold;
    assign dma_rd_data = rd_tag_dma ? mem_rd_data : dma_hold;

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            starve_cnt <= '0;
            rd_tag_cpu <= 1'b0;
            rd_tag_dma <= 1'b0;
            cpu_hold   <= '0;
            dma_hold   <= '0;
        end else begin
            if (grant_cpu && dma_valid) begin
                if (starve_cnt < MAX_CNT)
                    starve_cnt <= starve_cnt + CNT_W'(1);
            end else begin
                starve_cnt <= '0;
            end
            rd_tag_cpu <= grant_cpu && !cpu_wr;
            rd_tag_dma <= grant_dma && !dma_wr;
            if (rd_tag_cpu)
                cpu_hold <= mem_rd_data;
            if (rd_tag_dma)
                dma_hold <= mem_rd_data;
        end
    end

endmodule
